// File: rtl/gp_chain_pipe.sv
// gp_chain_pipe
//   Pipelined generate/propagate carry chain. WIDTH bit positions are resolved
//   SEG bits per stage over STAGES = WIDTH/SEG register stages, giving
//   c[i] = g[i] | (p[i] & c[i-1]) with c[-1] = carry in. The last stage
//   register is the output register. Valid/ready handshake on both sides
//   with a single advance enable (all stages move or all hold).
//
//   Optional feature, macro GP_CHAIN_LINK_EN: an operand set with
//   in_first = 0 continues the previous chain, taking its carry in from the
//   cout of the most recently retired result instead of in_cin. Such a set
//   is held off until its predecessor retires.
//
// Parameters
//   WIDTH  number of g/p bit positions (must be a multiple of SEG)
//   SEG    bits resolved per stage
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand set valid
//   in_ready   operand set accepted this cycle when in_valid is 1
//   in_g       generate vector
//   in_p       propagate vector
//   in_cin     carry into bit 0
//   in_first   set starts a new chain (used only with GP_CHAIN_LINK_EN)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_c      per-bit carry vector
//   out_cout   carry out, equal to out_c[WIDTH-1]

module gp_chain_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_g,
    input  logic [WIDTH-1:0] in_p,
    input  logic             in_cin,
    input  logic             in_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic             out_cout
);

    localparam int unsigned STAGES = WIDTH / SEG;
    localparam int unsigned CW     = $clog2(STAGES + 1);

    logic          en;
    logic          in_fire;
    logic          out_fire;
    logic          cin_eff;
    logic [CW-1:0] inflight;

    assign en       = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

`ifdef GP_CHAIN_LINK_EN
    logic link_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            link_c <= 1'b0;
        end else if (out_fire) begin
            link_c <= out_cout;
        end
    end

    // A linked set is only admitted when its predecessor is retiring this
    // very cycle (or already gone), so bypass the link register with the
    // retiring cout in the former case.
    assign cin_eff  = in_first ? in_cin : (out_fire ? out_cout : link_c);
    assign in_ready = en && (in_first || (inflight == '0) ||
                             ((inflight == CW'(1)) && out_fire));
`else
    logic unused_first;

    assign unused_first = in_first;
    assign cin_eff      = in_cin;
    assign in_ready     = en;
`endif

    // Stage k consumes the g/p bits from position k*SEG upwards (relative
    // index 0 is bit k*SEG), resolves the low SEG of them and forwards the
    // remainder. Resolved carries accumulate in c, growing by SEG per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned WI = WIDTH - k * SEG;
        localparam int unsigned WC = (k + 1) * SEG;

        logic [WI-1:0]  src_g;
        logic [WI-1:0]  src_p;
        logic           seg_cin;
        logic           v_in;
        logic [SEG-1:0] seg_c;
        logic [WC-1:0]  c_nxt;
        logic           v;
        logic [WC-1:0]  c;

        if (k == 0) begin : g_src
            assign src_g   = in_g;
            assign src_p   = in_p;
            assign seg_cin = cin_eff;
            assign v_in    = in_fire;
            assign c_nxt   = seg_c;
        end else begin : g_src
            assign src_g   = g_stage[k-1].g_fwd.g_r;
            assign src_p   = g_stage[k-1].g_fwd.p_r;
            assign seg_cin = g_stage[k-1].c[k*SEG-1];
            assign v_in    = g_stage[k-1].v;
            assign c_nxt   = {seg_c, g_stage[k-1].c};
        end

        always_comb begin
            logic carry;
            seg_c = '0;
            carry = seg_cin;
            for (int unsigned j = 0; j < SEG; j++) begin
                carry    = src_g[j] | (src_p[j] & carry);
                seg_c[j] = carry;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v <= 1'b0;
                c <= '0;
            end else if (en) begin
                v <= v_in;
                c <= c_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WI-SEG-1:0] g_r;
            logic [WI-SEG-1:0] p_r;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    g_r <= '0;
                    p_r <= '0;
                end else if (en) begin
                    g_r <= src_g[WI-1:SEG];
                    p_r <= src_p[WI-1:SEG];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v;
    assign out_c     = g_stage[STAGES-1].c;
    assign out_cout  = out_c[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (in_fire && !out_fire) begin
            inflight <= inflight + 1'b1;
        end else if (!in_fire && out_fire) begin
            inflight <= inflight - 1'b1;
        end
    end

endmodule

// File: doc/gp_chain_pipe.md
GP_CHAIN_PIPE -- requirements
Module: gp_chain_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the number of generate/propagate bit positions.
REQ-002 The module SHALL have parameter SEG, default 8, giving the bits resolved per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the input operand set is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-007 The module SHALL have port in_g, input, WIDTH bits: generate vector.
REQ-008 The module SHALL have port in_p, input, WIDTH bits: propagate vector.
REQ-009 The module SHALL have port in_cin, input, 1 bit: carry into bit 0.
REQ-010 The module SHALL have port in_first, input, 1 bit: the operand set starts a chain; it is ignored unless GP_CHAIN_LINK_EN is defined.
REQ-011 The module SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The module SHALL have port out_c, output, WIDTH bits: the per-bit carry vector.
REQ-014 The module SHALL have port out_cout, output, 1 bit: equal to out_c[WIDTH-1].

Function
REQ-015 The block SHALL compute c[0] = g[0] | (p[0] & cin) and c[i] = g[i] | (p[i] & c[i-1]) for i = 1 to WIDTH-1.
REQ-016 Stage k SHALL resolve bits k*SEG to k*SEG+SEG-1 using the carry registered by stage k-1, and SHALL forward the unresolved g/p bits in registers.
REQ-017 A transfer SHALL occur on a cycle where valid and ready are both 1; in_g, in_p, in_cin and in_first SHALL be sampled only on an input transfer.
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when there is no stall; throughput SHALL be 1 per cycle.
REQ-019 Pipeline advance enable SHALL be en = !out_valid | out_ready, and all stages SHALL hold while en = 0.
REQ-020 Without GP_CHAIN_LINK_EN, in_ready SHALL equal en.
REQ-021 The block SHALL hold at most STAGES results in flight, with no loss or duplication under any out_ready pattern.
REQ-022 out_c and out_cout SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-023 An in-flight counter, 0 to STAGES, SHALL increment on each input transfer and decrement on each output transfer; on a simultaneous input and output transfer it SHALL be unchanged.

Reset
REQ-024 While rst_n = 0 at a clock edge, all stage valid bits, out_valid, out_c, out_cout, the in-flight counter and the link carry register SHALL be cleared to 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight results, with no out_valid on the following cycle.
REQ-026 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-027 When macro GP_CHAIN_LINK_EN is defined, an operand set with in_first = 0 SHALL use the link carry register in place of in_cin.
REQ-028 With GP_CHAIN_LINK_EN defined, the link carry register SHALL load out_cout on every output transfer.
REQ-029 With GP_CHAIN_LINK_EN defined, in_ready SHALL equal en & (in_first | counter == 0 | (counter == 1 & out_valid & out_ready)), so that a linked operand set waits until its predecessor retires.
REQ-030 With GP_CHAIN_LINK_EN defined, an operand set with in_first = 1 SHALL use in_cin with no added stall.
REQ-031 When GP_CHAIN_LINK_EN is undefined, in_first SHALL be unused, the link register SHALL be absent, and behaviour SHALL be REQ-015 to REQ-026 only.

Verification (WIDTH=8, SEG=4, STAGES=2)
REQ-032 The bench SHALL drive g=0x01, p=0xFE, cin=0 and check out_c=0xFF, out_cout=1 exactly 2 cycles after acceptance.
REQ-033 The bench SHALL drive g=0x10, p=0x0F, cin=1 and check out_c=0x1F, out_cout=0; it SHALL then drive g=0x00, p=0xFF with cin=1 and then cin=0, back-to-back, and check 0xFF/1 followed by 0x00/0 on consecutive cycles.
REQ-034 The bench SHALL hold out_ready=0 for 6 cycles while offering 4 operand sets and check that in_ready falls after 2 acceptances, the output holds stable, and after release all sets emerge in order with no gaps or duplicates.
REQ-035 The bench SHALL assert rst_n=0 for 1 cycle while 2 results are in flight and check out_valid=0, counter=0 and in_ready=1 afterwards, with no stale result emerging.
REQ-036 With GP_CHAIN_LINK_EN defined, the bench SHALL send g=0x80, p=0x00, first=1 and then g=0x00, p=0xFF, first=0, cin=0, and check that the second set is stalled until the first retires, then yields out_c=0xFF, out_cout=1.
